// File: rtl/ctrl_pipe_chain_if.sv
// rtl/ctrl_pipe_chain_if.sv - valid/control-bundle bus used on both sides of the control pipe chain.
interface ctrl_pipe_chain_if #(
  parameter int WIDTH = 7
);
  logic             valid;
  logic [WIDTH-1:0] ctrl;

  modport master (output valid, ctrl);
  modport slave  (input  valid, ctrl);
endinterface

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - multi-stage control-bundle pipeline with stall, partial flush and status.
// Bubbles always carry an all-zero bundle so downstream enables stay inert.
module ctrl_pipe_chain #(
  parameter int WIDTH       = 7,
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16,
  localparam int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_pipe_chain_if.slave   in_bus,
  input  logic               stall,
  input  logic               flush,
  ctrl_pipe_chain_if.master  out_bus,
  output logic [OCC_W-1:0]   occupancy,
  output logic [CNT_W-1:0]   stall_cycles
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] c_q [DEPTH];
  logic [WIDTH-1:0] c_d [DEPTH];
  logic             load_in;
  logic             kill;

  // Flush overrides stall and forces one advance with the youngest stages killed.
  always_comb begin
    v_d     = v_q;
    load_in = in_bus.valid && !flush;
    kill    = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      c_d[k] = c_q[k];
    end
    if (flush || !stall) begin
      v_d[0] = load_in;
      c_d[0] = load_in ? in_bus.ctrl : '0;
      for (int k = 1; k < DEPTH; k++) begin
        kill   = flush && (k <= FLUSH_DEPTH);
        v_d[k] = v_q[k-1] && !kill;
        c_d[k] = kill ? '0 : c_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        c_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        c_q[k] <= c_d[k];
      end
    end
  end

  // Only cycles that actually hold the chain are counted; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && !flush && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(v_q[k]);
    end
  end

  assign out_bus.valid = v_q[DEPTH-1];
  assign out_bus.ctrl  = c_q[DEPTH-1];

endmodule
